// File: rtl/vc_demux_push.sv
// Routes each popped main-FIFO word into the VC0 or VC1 FIFO by one selector bit.
// A one-word skid register absorbs a full target VC; QoS counters track pushes and drops.
module vc_demux_push #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned VC_BIT = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              vc0_full,
  input  logic              vc1_full,
  output logic [DATA_W-1:0] vc0_data,
  output logic              vc0_push,
  output logic [DATA_W-1:0] vc1_data,
  output logic              vc1_push,
  output logic              busy,
  output logic              error,
  output logic [CNT_W-1:0]  vc0_cnt,
  output logic [CNT_W-1:0]  vc1_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] vc0_data_q, vc0_data_d, vc1_data_q, vc1_data_d;
  logic              vc0_push_q, vc0_push_d, vc1_push_q, vc1_push_d;
  logic              error_q, error_d;
  logic [CNT_W-1:0]  vc0_cnt_q, vc0_cnt_d, vc1_cnt_q, vc1_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  // Candidate word this cycle: the held word takes priority over the input.
  logic [DATA_W-1:0] word;
  logic              word_vld, tgt, tgt_full, do_push, drop_hit;

  always_comb begin
    word     = (state_q == StHold) ? hold_q : data_in;
    word_vld = (state_q == StHold) | valid_in;
    tgt      = word[VC_BIT];
    tgt_full = tgt ? vc1_full : vc0_full;
    do_push  = word_vld & ~tgt_full;
    drop_hit = (state_q == StHold) & valid_in;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (valid_in && tgt_full) state_d = StHold;
      StHold:  if (!tgt_full) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == StHold);
  end

  always_comb begin
    hold_d     = hold_q;
    vc0_push_d = do_push & ~tgt;
    vc1_push_d = do_push & tgt;
    vc0_data_d = vc0_push_d ? word : vc0_data_q;
    vc1_data_d = vc1_push_d ? word : vc1_data_q;
    vc0_cnt_d  = vc0_push_d ? vc0_cnt_q + 1'b1 : vc0_cnt_q;
    vc1_cnt_d  = vc1_push_d ? vc1_cnt_q + 1'b1 : vc1_cnt_q;
    drop_cnt_d = (drop_hit && (drop_cnt_q != '1)) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    error_d    = error_q | drop_hit;
    if ((state_q == StIdle) && valid_in && tgt_full) hold_d = data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q     <= '0;
      vc0_data_q <= '0;
      vc1_data_q <= '0;
      vc0_push_q <= 1'b0;
      vc1_push_q <= 1'b0;
      vc0_cnt_q  <= '0;
      vc1_cnt_q  <= '0;
      drop_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      vc0_data_q <= vc0_data_d;
      vc1_data_q <= vc1_data_d;
      vc0_push_q <= vc0_push_d;
      vc1_push_q <= vc1_push_d;
      vc0_cnt_q  <= vc0_cnt_d;
      vc1_cnt_q  <= vc1_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      error_q    <= error_d;
    end
  end

  assign vc0_data = vc0_data_q;
  assign vc1_data = vc1_data_q;
  assign vc0_push = vc0_push_q;
  assign vc1_push = vc1_push_q;
  assign vc0_cnt  = vc0_cnt_q;
  assign vc1_cnt  = vc1_cnt_q;
  assign drop_cnt = drop_cnt_q;
  assign error    = error_q;

endmodule

// File: tb/tb_vc_demux_push.sv
// Bench for vc_demux_push: directed table, corner sequences and random traffic,
// all checked against a queue-based reference model.
module tb_vc_demux_push;

  localparam int VcBit = 4;

  logic       clk = 1'b0;
  logic       reset, valid_in, vc0_full, vc1_full;
  logic [5:0] data_in, vc0_data, vc1_data;
  logic       vc0_push, vc1_push, busy, error;
  logic [7:0] vc0_cnt, vc1_cnt, drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  vc_demux_push dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .vc0_full (vc0_full),
    .vc1_full (vc1_full),
    .vc0_data (vc0_data),
    .vc0_push (vc0_push),
    .vc1_data (vc1_data),
    .vc1_push (vc1_push),
    .busy     (busy),
    .error    (error),
    .vc0_cnt  (vc0_cnt),
    .vc1_cnt  (vc1_cnt),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the skid register is a queue of at most one word.
  logic [5:0] held[$];
  bit         m_p0, m_p1, m_err;
  logic [5:0] m_d0, m_d1;
  int         m_c0, m_c1, m_drop;

  function automatic void m_clear();
    held.delete();
    m_p0 = 0; m_p1 = 0; m_err = 0;
    m_d0 = '0; m_d1 = '0;
    m_c0 = 0; m_c1 = 0; m_drop = 0;
  endfunction

  function automatic bit m_full(logic [5:0] w, bit f0, bit f1);
    return w[VcBit] ? f1 : f0;
  endfunction

  function automatic void m_push(logic [5:0] w);
    if (w[VcBit]) begin
      m_p1 = 1; m_d1 = w; m_c1 = (m_c1 + 1) % 256;
    end else begin
      m_p0 = 1; m_d0 = w; m_c0 = (m_c0 + 1) % 256;
    end
  endfunction

  function automatic void m_step(bit r, bit v, logic [5:0] d, bit f0, bit f1);
    m_p0 = 0; m_p1 = 0;
    if (r) begin
      m_clear();
    end else if (held.size() == 0) begin
      if (v) begin
        if (m_full(d, f0, f1)) held.push_back(d);
        else m_push(d);
      end
    end else begin
      if (v) begin
        m_err  = 1;
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end
      if (!m_full(held[0], f0, f1)) m_push(held.pop_front());
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("vc0_push", 32'(vc0_push), 32'(m_p0));
    chk("vc1_push", 32'(vc1_push), 32'(m_p1));
    chk("vc0_data", 32'(vc0_data), 32'(m_d0));
    chk("vc1_data", 32'(vc1_data), 32'(m_d1));
    chk("busy", 32'(busy), 32'(held.size() != 0));
    chk("error", 32'(error), 32'(m_err));
    chk("vc0_cnt", 32'(vc0_cnt), 32'(m_c0));
    chk("vc1_cnt", 32'(vc1_cnt), 32'(m_c1));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic step(input bit r, input bit v, input logic [5:0] d, input bit f0, input bit f1);
    reset = r; valid_in = v; data_in = d; vc0_full = f0; vc1_full = f1;
    @(posedge clk);
    m_step(r, v, d, f0, f1);
    #1;
    check_model();
  endtask

  typedef struct {
    bit r, v; logic [5:0] d; bit f0, f1;
    bit p0, p1; logic [5:0] pd; bit busy, err;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit r, bit v, logic [5:0] d, bit f0, bit f1,
                              bit p0, bit p1, logic [5:0] pd, bit b, bit e);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.f0 = f0; x.f1 = f1;
    x.p0 = p0; x.p1 = p1; x.pd = pd; x.busy = b; x.err = e;
    tbl.push_back(x);
  endfunction

  initial begin
    int start_c1;
    m_clear();
    reset = 1; valid_in = 0; data_in = '0; vc0_full = 0; vc1_full = 0;

    //   r  v  d      f0 f1  p0 p1 pd     busy err
    add(1, 0, 6'h00, 0, 0,  0, 0, 6'h00, 0, 0);  // reset held 2 cycles
    add(1, 0, 6'h00, 0, 0,  0, 0, 6'h00, 0, 0);
    add(0, 1, 6'h05, 0, 0,  1, 0, 6'h05, 0, 0);  // VC0 push, 1-cycle latency
    add(0, 0, 6'h00, 0, 0,  0, 0, 6'h00, 0, 0);
    add(0, 1, 6'h1A, 1, 0,  0, 1, 6'h1A, 0, 0);  // VC1; vc0_full does not block
    add(0, 1, 6'h02, 0, 0,  1, 0, 6'h02, 0, 0);  // back-to-back x4
    add(0, 1, 6'h13, 0, 0,  0, 1, 6'h13, 0, 0);
    add(0, 1, 6'h04, 0, 0,  1, 0, 6'h04, 0, 0);
    add(0, 1, 6'h15, 0, 0,  0, 1, 6'h15, 0, 0);
    add(0, 0, 6'h00, 0, 0,  0, 0, 6'h00, 0, 0);
    add(0, 1, 6'h03, 1, 0,  0, 0, 6'h00, 1, 0);  // target full -> hold
    add(0, 0, 6'h00, 1, 0,  0, 0, 6'h00, 1, 0);
    add(0, 1, 6'h11, 1, 0,  0, 0, 6'h00, 1, 1);  // dropped while busy
    add(0, 0, 6'h00, 1, 0,  0, 0, 6'h00, 1, 1);
    add(0, 0, 6'h00, 0, 0,  1, 0, 6'h03, 0, 1);  // drain held 03
    add(0, 0, 6'h00, 0, 0,  0, 0, 6'h00, 0, 1);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].f0, tbl[i].f1);
      chk("tbl_push0", 32'(vc0_push), 32'(tbl[i].p0));
      chk("tbl_push1", 32'(vc1_push), 32'(tbl[i].p1));
      chk("tbl_busy", 32'(busy), 32'(tbl[i].busy));
      chk("tbl_error", 32'(error), 32'(tbl[i].err));
      if (tbl[i].p0) chk("tbl_data0", 32'(vc0_data), 32'(tbl[i].pd));
      if (tbl[i].p1) chk("tbl_data1", 32'(vc1_data), 32'(tbl[i].pd));
    end
    chk("drop_after_tbl", 32'(drop_cnt), 32'd1);
    chk("vc0_cnt_after_tbl", 32'(vc0_cnt), 32'd4);

    // Drain cycle with a new word: word is dropped, held word still pushed
    step(0, 1, 6'h07, 1, 0);
    step(0, 1, 6'h08, 0, 0);
    chk("drain_push", 32'(vc0_push), 32'd1);
    chk("drain_data", 32'(vc0_data), 32'h07);
    chk("drain_drop", 32'(drop_cnt), 32'd2);

    // 256 VC1 pushes wrap the counter
    start_c1 = int'(vc1_cnt);
    for (int i = 0; i < 256; i++) step(0, 1, 6'h10 | 6'(i % 16), 0, 0);
    step(0, 0, 6'h00, 0, 0);
    chk("vc1_wrap", 32'(vc1_cnt), 32'(start_c1));

    // 260 drops saturate
    step(0, 1, 6'h01, 1, 1);
    for (int i = 0; i < 260; i++) step(0, 1, 6'h2A, 1, 1);
    chk("drop_sat", 32'(drop_cnt), 32'hFF);

    // Reset while holding discards the word
    step(1, 0, 6'h00, 1, 1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 6'h00, 0, 0);
      chk("no_ghost_push", 32'(vc0_push | vc1_push), 32'd0);
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, v, f0, f1;
      r  = ($urandom_range(0, 299) == 0);
      f0 = ($urandom_range(0, 2) == 0);
      f1 = ($urandom_range(0, 2) == 0);
      v  = (held.size() != 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) != 0);
      step(r, v, 6'($urandom), f0, f1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
